// File: rtl/keypad_scanner_pkg.sv
// Shared types and constants for the 4x4 keypad scanner and its debouncer.
package keypad_scanner_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int CODE_W   = 4;

  typedef struct packed {
    logic              valid;
    logic [CODE_W-1:0] code;
  } scan_result_t;

  // NONE always carries code 0 so equal "no key" scans compare equal.
  localparam scan_result_t RESULT_NONE = '{valid: 1'b0, code: 4'd0};

  typedef enum logic {
    IDLE    = 1'b0,
    PRESSED = 1'b1
  } kp_state_t;

  function automatic logic [NUM_COLS-1:0] col_drive(input logic [1:0] idx);
    logic [NUM_COLS-1:0] one_hot;
    one_hot = '0;
    one_hot[idx] = 1'b1;
    return ~one_hot;
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// Counts identical consecutive scan results and turns a stable key into a
// single press event; a stable "no key" is required before the next press.
module key_debouncer
  import keypad_scanner_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         scan_done_i,
  input  scan_result_t result_i,
  output logic         accept_o,
  output logic         key_valid_o,
  output logic         key_held_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);

  kp_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  scan_result_t     last_q, last_d;
  logic             valid_q, valid_d;
  logic             held_q, held_d;
  logic             stable;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    valid_d  = 1'b0;
    held_d   = held_q;
    accept_o = 1'b0;
    stable   = 1'b0;
    if (scan_done_i) begin
      if (result_i == last_q) begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d  = CNT_W'(1);
        last_d = result_i;
      end
      stable = (cnt_d == CNT_MAX);
      // A different stable key while PRESSED is ignored until a release.
      case (state_q)
        IDLE: begin
          if (stable && result_i.valid) begin
            state_d  = PRESSED;
            valid_d  = 1'b1;
            held_d   = 1'b1;
            accept_o = 1'b1;
          end
        end
        PRESSED: begin
          if (stable && !result_i.valid) begin
            state_d = IDLE;
            held_d  = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= RESULT_NONE;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

  assign key_valid_o = valid_q;
  assign key_held_o  = held_q;

endmodule

// File: rtl/keypad_scanner.sv
// Column-multiplexed 4x4 keypad reader: synchronises row returns, scans one
// column per tick, debounces full-scan results and shifts accepted codes.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_RATIO     = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                clk,
  input  logic                nReset,
  input  logic [NUM_ROWS-1:0] rows,
  input  logic                clr,
  output logic [NUM_COLS-1:0] cols,
  output logic [CODE_W-1:0]   key_code,
  output logic                key_valid,
  output logic                key_held,
  output logic [31:0]         digits
);

  localparam int DIV_W = $clog2(SCAN_RATIO);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_RATIO - 1);

  logic [NUM_ROWS-1:0] rows_meta_q, rows_sync_q;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [1:0]          col_q, col_d;
  logic [1:0]          hits_q, hits_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [CODE_W-1:0]   key_code_q, key_code_d;
  logic [31:0]         digits_q, digits_d;
  logic                tick;
  logic [2:0]          col_cnt;
  logic [1:0]          col_row;
  logic [2:0]          hits_sum;
  logic [1:0]          hits_sat;
  logic [CODE_W-1:0]   code_now;
  logic                scan_done;
  scan_result_t        scan_result;
  logic                accept;

  assign tick = (div_q == DIV_LAST);

  // Closed keys in the driven column; the highest closed row is the "last" one found.
  always_comb begin
    col_cnt = '0;
    col_row = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (!rows_sync_q[r]) begin
        col_cnt = col_cnt + 3'd1;
        col_row = 2'(r);
      end
    end
  end

  // Hit count saturates at 2: only "none", "exactly one" and "several" matter.
  always_comb begin
    div_d       = tick ? '0 : div_q + DIV_W'(1);
    col_d       = tick ? col_q + 2'd1 : col_q;
    hits_d      = hits_q;
    code_d      = code_q;
    scan_done   = 1'b0;
    scan_result = RESULT_NONE;
    hits_sum    = {1'b0, hits_q} + col_cnt;
    hits_sat    = (hits_sum >= 3'd2) ? 2'd2 : hits_sum[1:0];
    code_now    = (col_cnt != 3'd0) ? {col_row, col_q} : code_q;
    if (tick) begin
      if (col_q == 2'd3) begin
        scan_done = 1'b1;
        if (hits_sat == 2'd1) begin
          scan_result.valid = 1'b1;
          scan_result.code  = code_now;
        end
        hits_d = '0;
        code_d = '0;
      end else begin
        hits_d = hits_sat;
        code_d = code_now;
      end
    end
  end

  key_debouncer #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debouncer (
    .clk_i       (clk),
    .rst_ni      (nReset),
    .scan_done_i (scan_done),
    .result_i    (scan_result),
    .accept_o    (accept),
    .key_valid_o (key_valid),
    .key_held_o  (key_held)
  );

  // A clear in the accept cycle wins, dropping the new digit.
  always_comb begin
    key_code_d = key_code_q;
    digits_d   = digits_q;
    if (accept) begin
      key_code_d = scan_result.code;
      digits_d   = {digits_q[27:0], scan_result.code};
    end
    if (clr) digits_d = '0;
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      rows_meta_q <= '1;
      rows_sync_q <= '1;
      div_q       <= '0;
      col_q       <= '0;
      hits_q      <= '0;
      code_q      <= '0;
      key_code_q  <= '0;
      digits_q    <= '0;
    end else begin
      rows_meta_q <= rows;
      rows_sync_q <= rows_meta_q;
      div_q       <= div_d;
      col_q       <= col_d;
      hits_q      <= hits_d;
      code_q      <= code_d;
      key_code_q  <= key_code_d;
      digits_q    <= digits_d;
    end
  end

  assign cols     = col_drive(col_q);
  assign key_code = key_code_q;
  assign digits   = digits_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Keypad matrix model driving keypad_scanner; accepted presses are predicted
// into a queue and matched against every key_valid pulse.
module tb_keypad_scanner;

  localparam int SR   = 4;
  localparam int DB   = 2;
  localparam int SCAN = 16;

  logic        clk = 1'b0;
  logic        nReset = 1'b0;
  logic        clr = 1'b0;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [31:0] digits;
  logic [15:0] pressed = '0;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  int p0;

  typedef struct packed {
    logic [3:0]  code;
    logic [31:0] digits;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] model_digits = '0;

  keypad_scanner #(
    .SCAN_RATIO     (SR),
    .DEBOUNCE_SCANS (DB)
  ) dut (
    .clk       (clk),
    .nReset    (nReset),
    .rows      (rows),
    .clr       (clr),
    .cols      (cols),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held),
    .digits    (digits)
  );

  always #5 clk = ~clk;

  // Key index r*4+c shorts row r to column c.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !cols[c]) rows[r] = 1'b0;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic expect_press(input logic [3:0] code);
    exp_t e;
    model_digits = {model_digits[27:0], code};
    e.code   = code;
    e.digits = model_digits;
    exp_q.push_back(e);
  endtask

  task automatic wait_scans(input int n);
    repeat (n * SCAN) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (nReset && key_valid) begin
      pulses++;
      check_eq("pulse_expected", 32'(exp_q.size() == 0), 32'd0);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check_eq("pulse_code", {28'd0, key_code}, {28'd0, mon_e.code});
        check_eq("pulse_digits", digits, mon_e.digits);
      end
    end
  end

  initial begin
    // Reset state and column rotation.
    #12;
    check_eq("rst_cols", {28'd0, cols}, 32'hE);
    check_eq("rst_code", {28'd0, key_code}, 32'd0);
    check_eq("rst_valid", {31'd0, key_valid}, 32'd0);
    check_eq("rst_held", {31'd0, key_held}, 32'd0);
    check_eq("rst_digits", digits, 32'd0);
    @(negedge clk);
    nReset = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_eq("cols_3clk", {28'd0, cols}, 32'hE);
    @(posedge clk);
    #1 check_eq("cols_4clk", {28'd0, cols}, 32'hD);
    repeat (12) @(posedge clk);
    #1 check_eq("cols_16clk", {28'd0, cols}, 32'hE);

    // Single press and release of key 6.
    pressed[6] = 1'b1;
    expect_press(4'h6);
    wait_scans(4);
    check_eq("k6_held", {31'd0, key_held}, 32'd1);
    check_eq("k6_code", {28'd0, key_code}, 32'h6);
    check_eq("k6_digits", digits, 32'h00000006);
    check_eq("k6_pending", exp_q.size(), 32'd0);
    pressed[6] = 1'b0;
    wait_scans(3);
    check_eq("k6_released", {31'd0, key_held}, 32'd0);
    check_eq("k6_pulses", pulses, 32'd1);

    // Bounce: alternating scans never accumulate two equal results.
    for (int i = 0; i < 6; i++) begin
      pressed[6] = ~pressed[6];
      wait_scans(1);
    end
    pressed[6] = 1'b1;
    expect_press(4'h6);
    p0 = pulses;
    wait_scans(1);
    check_eq("bounce_early", pulses, p0);
    wait_scans(2);
    check_eq("bounce_pending", exp_q.size(), 32'd0);
    check_eq("bounce_pulses", pulses, p0 + 1);
    pressed[6] = 1'b0;
    wait_scans(3);

    // Digit sequence 1,2,A,F after a clear.
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
    model_digits = '0;
    check_eq("clr1_digits", digits, 32'd0);
    for (int i = 0; i < 4; i++) begin
      logic [3:0] k;
      k = (i == 0) ? 4'h1 : (i == 1) ? 4'h2 : (i == 2) ? 4'hA : 4'hF;
      pressed[k] = 1'b1;
      expect_press(k);
      wait_scans(4);
      pressed[k] = 1'b0;
      wait_scans(3);
    end
    check_eq("seq_digits", digits, 32'h000012AF);
    check_eq("seq_pending", exp_q.size(), 32'd0);
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
    model_digits = '0;
    check_eq("clr2_digits", digits, 32'd0);
    check_eq("clr2_code", {28'd0, key_code}, 32'hF);

    // Ghosting: two keys together are ignored.
    p0 = pulses;
    pressed[0] = 1'b1;
    pressed[5] = 1'b1;
    wait_scans(4);
    check_eq("ghost_pulses", pulses, p0);
    check_eq("ghost_held", {31'd0, key_held}, 32'd0);
    pressed[5] = 1'b0;
    expect_press(4'h0);
    wait_scans(4);
    check_eq("ghost_k0_pending", exp_q.size(), 32'd0);
    check_eq("ghost_k0_code", {28'd0, key_code}, 32'h0);
    check_eq("ghost_k0_held", {31'd0, key_held}, 32'd1);
    pressed[0] = 1'b0;
    wait_scans(3);

    // Reset while key 6 is held.
    pressed[6] = 1'b1;
    expect_press(4'h6);
    wait_scans(4);
    check_eq("rk6_held", {31'd0, key_held}, 32'd1);
    @(negedge clk);
    #2 nReset = 1'b0;
    #1;
    check_eq("mid_rst_cols", {28'd0, cols}, 32'hE);
    check_eq("mid_rst_code", {28'd0, key_code}, 32'd0);
    check_eq("mid_rst_held", {31'd0, key_held}, 32'd0);
    check_eq("mid_rst_valid", {31'd0, key_valid}, 32'd0);
    check_eq("mid_rst_digits", digits, 32'd0);
    model_digits = '0;
    @(negedge clk) nReset = 1'b1;
    expect_press(4'h6);
    p0 = pulses;
    repeat (24) @(posedge clk);
    #1 check_eq("post_rst_early", pulses, p0);
    wait_scans(2);
    check_eq("post_rst_pulses", pulses, p0 + 1);
    check_eq("post_rst_pending", exp_q.size(), 32'd0);
    check_eq("post_rst_held", {31'd0, key_held}, 32'd1);
    pressed[6] = 1'b0;
    wait_scans(3);
    check_eq("final_held", {31'd0, key_held}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
